// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - rv32i pipeline sequencer: load-use stalls, redirect squash, memory freeze
module pipe_ctrl #(
    parameter int REDIRECT_PENALTY = 1,
    parameter int CNT_W            = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_valid,
    input  logic [4:0]       de_rs1,
    input  logic [4:0]       de_rs2,
    input  logic             de_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_we,
    output logic             fd_we,
    output logic             de_we,
    output logic             fd_flush,
    output logic             de_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, SQUASH} state_t;

    state_t     state, state_nxt;
    logic [2:0] sq_cnt, sq_nxt;
    logic       freeze, redirect, hz, squashing, flush_inc;

    assign freeze   = mem_req & ~mem_ack;
    assign redirect = ex_redirect & ex_valid;
    assign hz       = ex_valid & ex_is_load & (ex_rd != 5'd0) & de_valid &
                      ((ex_rd == de_rs1) | (de_uses_rs2 & (ex_rd == de_rs2)));
    // A squash interrupted by a freeze resumes on the ack cycle, so track it by sq_cnt.
    assign squashing = (sq_cnt != 3'd0);

    always_comb begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        de_we     = 1'b1;
        fd_flush  = 1'b0;
        de_bubble = 1'b0;
        state_nxt = state;
        sq_nxt    = sq_cnt;
        flush_inc = 1'b0;
        if (rst) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            de_we     = 1'b0;
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            state_nxt = RUN;
            sq_nxt    = 3'd0;
        end else if (freeze) begin
            pc_we     = 1'b0;
            fd_we     = 1'b0;
            de_we     = 1'b0;
            state_nxt = MEM_WAIT;
        end else if (redirect) begin
            fd_flush  = 1'b1;
            de_bubble = 1'b1;
            flush_inc = 1'b1;
            sq_nxt    = 3'(REDIRECT_PENALTY);
            state_nxt = SQUASH;
        end else if (squashing) begin
            // fd_flush is high here, which masks load-use detection.
            fd_flush  = 1'b1;
            sq_nxt    = sq_cnt - 3'd1;
            state_nxt = (sq_cnt == 3'd1) ? RUN : SQUASH;
        end else begin
            state_nxt = RUN;
            if (hz) begin
                pc_we     = 1'b0;
                fd_we     = 1'b0;
                de_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            sq_cnt    <= 3'd0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state  <= state_nxt;
            sq_cnt <= sq_nxt;
            if (!pc_we && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_inc && (flush_cnt != {CNT_W{1'b1}}))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - scoreboard bench for pipe_ctrl (penalty 2 main, 4-bit counter second)
module tb_pipe_ctrl;

    localparam logic [4:0] RUNV = 5'b11100;
    localparam logic [4:0] STL  = 5'b00101;
    localparam logic [4:0] RDR  = 5'b11111;
    localparam logic [4:0] SQV  = 5'b11110;
    localparam logic [4:0] FRZ  = 5'b00000;
    localparam logic [4:0] RSTV = 5'b00011;

    typedef struct {
        logic       rst;
        logic       de_valid;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses2;
        logic       ex_valid;
        logic       ld;
        logic [4:0] rd;
        logic       redir;
        logic       mreq;
        logic       mack;
        logic [4:0] exp;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        de_valid = 1'b0, de_uses_rs2 = 1'b0, ex_valid = 1'b0, ex_is_load = 1'b0;
    logic [4:0]  de_rs1 = 5'd0, de_rs2 = 5'd0, ex_rd = 5'd0;
    logic        ex_redirect = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;
    logic        pc_we, fd_we, de_we, fd_flush, de_bubble;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_we_s, fd_we_s, de_we_s, fd_flush_s, de_bubble_s;
    logic [3:0]  stall_cnt_s, flush_cnt_s;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [15:0] exp_flush = 16'd0;
    logic [3:0]  exp_stall_s = 4'd0;
    logic [4:0]  sb[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.REDIRECT_PENALTY(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_uses_rs2(de_uses_rs2), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack), .pc_we(pc_we),
        .fd_we(fd_we), .de_we(de_we), .fd_flush(fd_flush), .de_bubble(de_bubble),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_ctrl #(.REDIRECT_PENALTY(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .de_valid(de_valid), .de_rs1(de_rs1), .de_rs2(de_rs2),
        .de_uses_rs2(de_uses_rs2), .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack), .pc_we(pc_we_s),
        .fd_we(fd_we_s), .de_we(de_we_s), .fd_flush(fd_flush_s), .de_bubble(de_bubble_s),
        .stall_cnt(stall_cnt_s), .flush_cnt(flush_cnt_s)
    );

    function automatic stim_t s(input logic r, input logic dv, input logic [4:0] r1,
                                input logic [4:0] r2, input logic u2, input logic ev,
                                input logic ld, input logic [4:0] rd, input logic rdr,
                                input logic mq, input logic ma, input logic [4:0] e);
        stim_t t;
        t.rst = r; t.de_valid = dv; t.rs1 = r1; t.rs2 = r2; t.uses2 = u2; t.ex_valid = ev;
        t.ld = ld; t.rd = rd; t.redir = rdr; t.mreq = mq; t.mack = ma; t.exp = e;
        return t;
    endfunction

    // Drives one cycle of stimulus and pushes the expected enables and counter effects.
    task automatic apply(input stim_t t);
        rst = t.rst; de_valid = t.de_valid; de_rs1 = t.rs1; de_rs2 = t.rs2;
        de_uses_rs2 = t.uses2; ex_valid = t.ex_valid; ex_is_load = t.ld; ex_rd = t.rd;
        ex_redirect = t.redir; mem_req = t.mreq; mem_ack = t.mack;
        sb.push_back(t.exp);
        if (t.rst) begin
            exp_stall = 16'd0; exp_stall_s = 4'd0; exp_flush = 16'd0;
        end else begin
            if (!t.exp[4]) begin
                if (exp_stall != 16'hffff) exp_stall = exp_stall + 16'd1;
                if (exp_stall_s != 4'hf) exp_stall_s = exp_stall_s + 4'd1;
            end
            if (t.exp == RDR) exp_flush = exp_flush + 16'd1;
        end
    endtask

    task automatic test_reset();
        stim_t rows[$];
        logic [4:0] e, got;
        rows.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RSTV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
        rows.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RSTV));
        rows.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RSTV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = {pc_we, fd_we, de_we, fd_flush, de_bubble};
            total++;
            if (got !== e) begin bad++; $display("FAIL reset[%0d] enables: got=%b exp=%b", i, got, e); end
            @(posedge clk); #1;
            total++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
                bad++;
                $display("FAIL reset[%0d] counters: got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t rows[$];
        logic [4:0] e, got;
        rows.push_back(s(0, 1, 5, 1, 1, 1, 1, 5, 0, 0, 0, STL));
        rows.push_back(s(0, 1, 5, 1, 1, 0, 0, 0, 0, 0, 0, RUNV));
        rows.push_back(s(0, 1, 0, 1, 1, 1, 1, 0, 0, 0, 0, RUNV));
        rows.push_back(s(0, 1, 3, 5, 0, 1, 1, 5, 0, 0, 0, RUNV));
        rows.push_back(s(0, 1, 3, 5, 1, 1, 1, 5, 0, 0, 0, STL));
        rows.push_back(s(0, 1, 3, 5, 1, 0, 0, 5, 0, 0, 0, RUNV));
        rows.push_back(s(0, 0, 5, 5, 1, 1, 1, 5, 0, 0, 0, RUNV));
        rows.push_back(s(0, 1, 7, 7, 1, 1, 0, 7, 0, 0, 0, RUNV));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = {pc_we, fd_we, de_we, fd_flush, de_bubble};
            total++;
            if (got !== e) begin bad++; $display("FAIL load_use[%0d] enables: got=%b exp=%b", i, got, e); end
            @(posedge clk); #1;
            total++;
            if (stall_cnt !== exp_stall) begin
                bad++;
                $display("FAIL load_use[%0d] stall_cnt: got=%0d exp=%0d", i, stall_cnt, exp_stall);
            end
        end
    endtask

    task automatic test_redirect();
        stim_t rows[$];
        logic [4:0] e, got;
        rows.push_back(s(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, RDR));
        rows.push_back(s(0, 1, 5, 0, 0, 1, 1, 5, 0, 0, 0, SQV));
        rows.push_back(s(0, 1, 5, 0, 0, 1, 1, 5, 0, 0, 0, SQV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, RUNV));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = {pc_we, fd_we, de_we, fd_flush, de_bubble};
            total++;
            if (got !== e) begin bad++; $display("FAIL redirect[%0d] enables: got=%b exp=%b", i, got, e); end
            @(posedge clk); #1;
            total++;
            if (flush_cnt !== exp_flush || stall_cnt !== exp_stall) begin
                bad++;
                $display("FAIL redirect[%0d] counters: got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t rows[$];
        logic [4:0] e, got;
        rows.push_back(s(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, RDR));
        rows.push_back(s(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, RDR));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SQV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SQV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = {pc_we, fd_we, de_we, fd_flush, de_bubble};
            total++;
            if (got !== e) begin bad++; $display("FAIL back_to_back[%0d] enables: got=%b exp=%b", i, got, e); end
            @(posedge clk); #1;
            total++;
            if (flush_cnt !== exp_flush) begin
                bad++;
                $display("FAIL back_to_back[%0d] flush_cnt: got=%0d exp=%0d", i, flush_cnt, exp_flush);
            end
        end
    endtask

    task automatic test_freeze();
        stim_t rows[$];
        logic [4:0] e, got;
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV));
        for (int k = 0; k < 4; k++)
            rows.push_back(s(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, FRZ));
        rows.push_back(s(0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 1, RDR));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SQV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SQV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        rows.push_back(s(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, RDR));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, FRZ));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, SQV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, SQV));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = {pc_we, fd_we, de_we, fd_flush, de_bubble};
            total++;
            if (got !== e) begin bad++; $display("FAIL freeze[%0d] enables: got=%b exp=%b", i, got, e); end
            @(posedge clk); #1;
            total++;
            if (stall_cnt !== exp_stall || flush_cnt !== exp_flush) begin
                bad++;
                $display("FAIL freeze[%0d] counters: got=%0d/%0d exp=%0d/%0d", i, stall_cnt, flush_cnt, exp_stall, exp_flush);
            end
        end
    endtask

    task automatic test_saturation();
        stim_t rows[$];
        logic [4:0] e, got;
        rows.push_back(s(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV));
        for (int k = 0; k < 20; k++)
            rows.push_back(s(0, 1, 9, 0, 0, 1, 1, 9, 0, 0, 0, STL));
        rows.push_back(s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RUNV));
        foreach (rows[i]) begin
            apply(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            got = {pc_we_s, fd_we_s, de_we_s, fd_flush_s, de_bubble_s};
            total++;
            if (got !== e) begin bad++; $display("FAIL saturation[%0d] enables: got=%b exp=%b", i, got, e); end
            @(posedge clk); #1;
            total++;
            if (stall_cnt_s !== exp_stall_s || stall_cnt !== exp_stall) begin
                bad++;
                $display("FAIL saturation[%0d] stall_cnt: got=%0d/%0d exp=%0d/%0d", i, stall_cnt_s, stall_cnt, exp_stall_s, exp_stall);
            end
        end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_load_use();
        test_redirect();
        test_back_to_back();
        test_freeze();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
